// File: rtl/cmn_pwm_pkg.sv
// cmn_pwm_pkg: host register map, watchdog clear key and command FSM states for cmn_pwm_cmd
package cmn_pwm_pkg;
  localparam logic [2:0] ADDR_P01 = 3'd0;
  localparam logic [2:0] ADDR_P23 = 3'd1;
  localparam logic [2:0] ADDR_P45 = 3'd2;
  localparam logic [2:0] ADDR_BRK = 3'd3;
  localparam logic [2:0] ADDR_EN  = 3'd4;
  localparam logic [2:0] ADDR_CLR = 3'd5;
  localparam logic [9:0] WDOG_KEY = 10'h15A;
  typedef enum logic [1:0] {IDLE, RUN, EXPIRED} state_t;
endpackage

// File: rtl/cmn_slew_lim.sv
// cmn_slew_lim: one channel ramp register (cur) stepping toward tgt by at most STEP per tick; ports clk, reset, tick, tgt in, cur out
module cmn_slew_lim #(
  parameter int W    = 10,
  parameter int STEP = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         tick,
  input  logic [W-1:0] tgt,
  output logic [W-1:0] cur
);
  localparam logic [W:0]   STEP_W = (W+1)'(STEP);
  localparam logic [W-1:0] STEP_N = W'(STEP);
  logic [W:0]   up, dn;
  logic [W-1:0] nxt;
  always_comb begin
    up  = {1'b0, tgt} - {1'b0, cur};
    dn  = {1'b0, cur} - {1'b0, tgt};
    nxt = (tgt >= cur) ? ((up <= STEP_W) ? tgt : cur + STEP_N)
                       : ((dn <= STEP_W) ? tgt : cur - STEP_N);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) cur <= '0;
    else if (tick) cur <= nxt;
endmodule

// File: rtl/cmn_pwm_cmd.sv
// cmn_pwm_cmd: host duty/enable command stage with slew limit, period-aligned outputs and host watchdog; host wr_* in, duties/enables/status out
module cmn_pwm_cmd
  import cmn_pwm_pkg::*;
#(
  parameter int DUTY_WIDTH = 10,
  parameter int SLEW_STEP  = 8,
  parameter int WDOG_TICKS = 50
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pulse_200us,
  input  logic                  start_pwm_period,
  input  logic                  wr_en,
  input  logic [2:0]            wr_addr,
  input  logic [DUTY_WIDTH-1:0] wr_data,
  output logic                  wr_ack,
  output logic [DUTY_WIDTH-1:0] mot_pwm_param01,
  output logic [DUTY_WIDTH-1:0] mot_pwm_param23,
  output logic [DUTY_WIDTH-1:0] mot_pwm_param45,
  output logic [DUTY_WIDTH-1:0] brk_pwm_param,
  output logic                  mot_en_in,
  output logic                  brk_en_in,
  output logic                  wdog_expired,
  output logic                  ramp_busy
);
  localparam int CW = (WDOG_TICKS > 0) ? $clog2(WDOG_TICKS + 1) : 1;
  localparam logic [CW-1:0] WDOG_LAST = CW'((WDOG_TICKS > 0) ? WDOG_TICKS - 1 : 0);
  state_t state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [1:0] en_req, en_req_nxt;
  logic wr_ch, wr_valid, clr_ok, expire;
  logic [DUTY_WIDTH-1:0] tgt [4];
  logic [DUTY_WIDTH-1:0] cur [4];
  logic [DUTY_WIDTH-1:0] out [4];
  always_comb begin
    wr_ch      = wr_en && wr_addr <= ADDR_BRK;
    wr_valid   = wr_en && wr_addr <= ADDR_EN;
    clr_ok     = wr_en && wr_addr == ADDR_CLR && wr_data == DUTY_WIDTH'(WDOG_KEY);
    expire     = state == RUN && WDOG_TICKS != 0 && pulse_200us && !wr_valid && cnt == WDOG_LAST;
    state_nxt  = (state == IDLE) ? (wr_valid ? RUN : IDLE)
               : (state == RUN)  ? (expire ? EXPIRED : RUN)
               : (clr_ok ? RUN : EXPIRED);
    cnt_nxt    = (state != RUN || state_nxt != RUN || wr_valid) ? '0
               : pulse_200us ? cnt + 1'b1 : cnt;
    en_req_nxt = (state_nxt == EXPIRED) ? 2'b00
               : (state != EXPIRED && wr_en && wr_addr == ADDR_EN) ? wr_data[1:0] : en_req;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nxt;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cnt       <= '0;
      en_req    <= '0;
      mot_en_in <= 1'b0;
      brk_en_in <= 1'b0;
      wr_ack    <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        tgt[k] <= '0;
        out[k] <= '0;
      end
    end else begin
      cnt       <= cnt_nxt;
      en_req    <= en_req_nxt;
      wr_ack    <= wr_en;
      mot_en_in <= en_req_nxt[0] && (mot_en_in || (start_pwm_period && en_req[0]));
      brk_en_in <= en_req_nxt[1] && (brk_en_in || (start_pwm_period && en_req[1]));
      for (int k = 0; k < 4; k++) begin
        if (state_nxt == EXPIRED) tgt[k] <= '0;
        else if (state != EXPIRED && wr_ch && wr_addr[1:0] == 2'(k)) tgt[k] <= wr_data;
        if (start_pwm_period) out[k] <= cur[k];
      end
    end
  for (genvar i = 0; i < 4; i++) begin : g_ch
    cmn_slew_lim #(.W(DUTY_WIDTH), .STEP(SLEW_STEP)) u_slew (
      .clk  (clk),
      .reset(reset),
      .tick (pulse_200us),
      .tgt  (tgt[i]),
      .cur  (cur[i])
    );
  end
  always_comb begin
    ramp_busy = 1'b0;
    for (int k = 0; k < 4; k++) ramp_busy = ramp_busy | (cur[k] != tgt[k]) | (out[k] != cur[k]);
  end
  assign wdog_expired    = state == EXPIRED;
  assign mot_pwm_param01 = out[ADDR_P01[1:0]];
  assign mot_pwm_param23 = out[ADDR_P23[1:0]];
  assign mot_pwm_param45 = out[ADDR_P45[1:0]];
  assign brk_pwm_param   = out[ADDR_BRK[1:0]];
endmodule

// File: tb/tb_cmn_pwm_cmd.sv
// tb_cmn_pwm_cmd: directed scoreboard bench for cmn_pwm_cmd
module tb_cmn_pwm_cmd;
  logic clk = 0, reset = 1, pulse_200us = 0, start_pwm_period = 0, wr_en = 0;
  logic [2:0] wr_addr = '0;
  logic [9:0] wr_data = '0;
  logic wr_ack, mot_en_in, brk_en_in, wdog_expired, ramp_busy;
  logic [9:0] p01, p23, p45, pbrk;
  typedef struct {string tag; logic [15:0] val;} exp_t;
  exp_t sb[$];
  int vectors = 0, miscompares = 0;
  always #5 clk = ~clk;
  cmn_pwm_cmd dut (
    .clk(clk), .reset(reset), .pulse_200us(pulse_200us), .start_pwm_period(start_pwm_period),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .mot_pwm_param01(p01), .mot_pwm_param23(p23), .mot_pwm_param45(p45), .brk_pwm_param(pbrk),
    .mot_en_in(mot_en_in), .brk_en_in(brk_en_in), .wdog_expired(wdog_expired), .ramp_busy(ramp_busy)
  );
  task automatic ex(input string tag, input logic [15:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask
  task automatic ck(input logic [15:0] obs);
    exp_t e;
    vectors++;
    if (sb.size() == 0) begin
      miscompares++;
      $error("FAIL sb_empty: got %0h expected nothing", obs);
      return;
    end
    e = sb.pop_front();
    assert (obs === e.val) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h", e.tag, obs, e.val);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [2:0] a, input logic [9:0] d, input bit with_tick = 0);
    wr_en = 1; wr_addr = a; wr_data = d; pulse_200us = with_tick;
    ex("wr_ack", 1);
    step();
    ck({15'd0, wr_ack});
    wr_en = 0; pulse_200us = 0;
  endtask
  task automatic tick(input int n);
    repeat (n) begin
      pulse_200us = 1; step(); pulse_200us = 0; step();
    end
  endtask
  task automatic strobe();
    start_pwm_period = 1; step(); start_pwm_period = 0;
  endtask
  task automatic kick_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      if (i % 40 == 0) wr(3'd4, 10'd3);
      tick(1);
    end
  endtask
  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
  initial begin
    step(); step();
    ex("rst_p01", 0); ck(p01);
    ex("rst_p23", 0); ck(p23);
    ex("rst_p45", 0); ck(p45);
    ex("rst_brk", 0); ck(pbrk);
    ex("rst_en", 0); ck({14'd0, mot_en_in, brk_en_in});
    ex("rst_wdog", 0); ck({15'd0, wdog_expired});
    ex("rst_ack", 0); ck({15'd0, wr_ack});
    ex("rst_busy", 0); ck({15'd0, ramp_busy});
    reset = 0;
    wr(3'd0, 10'h100);
    ex("busy_after_wr", 1); ck({15'd0, ramp_busy});
    wr(3'd4, 10'd3);
    ex("en_before_strobe", 0); ck({14'd0, mot_en_in, brk_en_in});
    strobe();
    ex("en_at_strobe", 3); ck({14'd0, mot_en_in, brk_en_in});
    tick(31); strobe();
    ex("up_31", 10'h0F8); ck(p01);
    tick(1);
    ex("busy_port_lag", 1); ck({15'd0, ramp_busy});
    strobe();
    ex("up_32", 10'h100); ck(p01);
    ex("busy_settled", 0); ck({15'd0, ramp_busy});
    wr(3'd0, 10'h005);
    tick(31); strobe();
    ex("dn_31", 10'h008); ck(p01);
    tick(1);
    ex("busy_dn_lag", 1); ck({15'd0, ramp_busy});
    strobe();
    ex("dn_final", 10'h005); ck(p01);
    ex("busy_dn_done", 0); ck({15'd0, ramp_busy});
    tick(1); strobe();
    ex("dn_no_under", 10'h005); ck(p01);
    wr(3'd1, 10'h3FC);
    kick_ticks(128); strobe();
    ex("up_3fc", 10'h3FC); ck(p23);
    wr(3'd1, 10'h3FF); tick(1); strobe();
    ex("top_3ff", 10'h3FF); ck(p23);
    wr(3'd2, 10'h003); tick(1); strobe();
    ex("small_up", 10'h003); ck(p45);
    wr(3'd2, 10'h000); tick(1); strobe();
    ex("to_zero", 10'h000); ck(p45);
    wr(3'd3, 10'h008); tick(1); strobe();
    ex("exact_step0", 10'h008); ck(pbrk);
    wr(3'd3, 10'h010); tick(1); strobe();
    ex("exact_step1", 10'h010); ck(pbrk);
    wr(3'd3, 10'h040); tick(1);
    pulse_200us = 1; start_pwm_period = 1; step(); pulse_200us = 0; start_pwm_period = 0;
    ex("tick_strobe_pre", 10'h018); ck(pbrk);
    wr(3'd3, 10'h020, 1); strobe();
    ex("wr_tick_oldtgt", 10'h028); ck(pbrk);
    tick(1); strobe();
    ex("wr_tick_newtgt", 10'h020); ck(pbrk);
    ex("busy_all_idle", 0); ck({15'd0, ramp_busy});
    wr(3'd4, 10'd3);
    tick(49);
    wr(3'd4, 10'd3, 1);
    ex("wdog_wr_wins", 0); ck({15'd0, wdog_expired});
    tick(49);
    ex("wdog_49", 0); ck({15'd0, wdog_expired});
    tick(1);
    ex("wdog_50", 1); ck({15'd0, wdog_expired});
    ex("wdog_en_off", 0); ck({14'd0, mot_en_in, brk_en_in});
    ex("wdog_busy", 1); ck({15'd0, ramp_busy});
    ex("wdog_port_hold", 10'h005); ck(p01);
    wr(3'd0, 10'h200);
    wr(3'd5, 10'h155);
    ex("bad_key", 1); ck({15'd0, wdog_expired});
    wr(3'd4, 10'd3); strobe();
    ex("exp_en_discard", 0); ck({14'd0, mot_en_in, brk_en_in});
    tick(128); strobe();
    ex("exp_p01", 0); ck(p01);
    ex("exp_p23", 0); ck(p23);
    ex("exp_p45", 0); ck(p45);
    ex("exp_brk", 0); ck(pbrk);
    ex("exp_busy", 0); ck({15'd0, ramp_busy});
    wr(3'd5, 10'h15A);
    ex("key_clear", 0); ck({15'd0, wdog_expired});
    strobe();
    ex("clr_tgt_zero", 0); ck(p01);
    wr(3'd4, 10'd3); strobe();
    ex("run_en", 3); ck({14'd0, mot_en_in, brk_en_in});
    wr(3'd0, 10'h100); tick(3); strobe();
    ex("pre_reset", 10'h018); ck(p01);
    #3 reset = 1;
    #1;
    ex("async_p01", 0); ck(p01);
    ex("async_en", 0); ck({14'd0, mot_en_in, brk_en_in});
    ex("async_busy", 0); ck({15'd0, ramp_busy});
    #2 reset = 0;
    step();
    tick(60);
    ex("idle_no_wdog", 0); ck({15'd0, wdog_expired});
    wr(3'd0, 10'h008); tick(1); strobe();
    ex("post_rst_wr", 10'h008); ck(p01);
    tick(48);
    ex("post_rst_49", 0); ck({15'd0, wdog_expired});
    tick(1);
    ex("post_rst_run", 1); ck({15'd0, wdog_expired});
    vectors++;
    assert (sb.size() == 0) else begin
      miscompares++;
      $error("FAIL sb_leftover: got %0d expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/cmn_pwm_cmd.md
# cmn_pwm_cmd

Command stage directly upstream of `cmn_pwm`. It accepts host duty and enable writes and slew-limits each duty toward its target once per `pulse_200us` tick. It presents the four 10-bit PWM parameters and the two enables to `cmn_pwm`, changing duty only on PWM period boundaries. A host watchdog forces a ramp-down and disables both bridges when the host stops writing.

## Interface
- `DUTY_WIDTH`, 10: width of every duty target, ramp and output register.
- `SLEW_STEP`, 8: maximum duty change per `pulse_200us` tick.
- `WDOG_TICKS`, 50: watchdog timeout in `pulse_200us` ticks (50 = 10 ms); 0 disables the watchdog.
- `clk`  in  1  system clock. One clock domain.
- `reset`  in  1  asynchronous, active-high reset.
- `pulse_200us`  in  1  one-cycle timebase tick.
- `start_pwm_period`  in  1  one-cycle period-boundary strobe from `cmn_pwm.start_pwm_period_out`.
- `wr_en`  in  1  host write strobe.
- `wr_addr`  in  3  register address.
- `wr_data`  in  DUTY_WIDTH  write data.
- `wr_ack`  out  1  one-cycle acknowledge.
- `mot_pwm_param01`, `mot_pwm_param23`, `mot_pwm_param45`, `brk_pwm_param`  out  DUTY_WIDTH  duties to `cmn_pwm`.
- `mot_en_in`, `brk_en_in`  out  1  enables to `cmn_pwm`.
- `wdog_expired`  out  1  watchdog latched.
- `ramp_busy`  out  1  any channel not settled.

## Operation
- Channel/address map:
  - 0 = param01, 1 = param23, 2 = param45, 3 = brk.
  - 4 = enable request: bit0 motor, bit1 brake.
  - 5 = watchdog clear; the key is 10'h15A.
  - 6–7 are ignored.
- Every write is acked, including ignored writes.
- Per channel there are three registers:
  - `tgt`: the written target.
  - `cur`: the ramp value.
  - `out`: the port value.
- Slew on each `pulse_200us`:
  - If |tgt−cur| ≤ SLEW_STEP, then cur = tgt.
  - Otherwise cur moves toward tgt by SLEW_STEP.
  - Differences are computed at DUTY_WIDTH+1 bits; no wrap and no overshoot.
- Output load: on `start_pwm_period`, out ← cur for all four channels simultaneously.
- Enables:
  - Assertion takes effect at the first `start_pwm_period` after the request.
  - Deassertion (request cleared or watchdog) is immediate, on the next clock edge.
- State machine:
  - IDLE (after reset): targets 0, enables off, watchdog not counting. Any write to addr 0–4 performs the write and moves to RUN.
  - RUN: each valid write to addr 0–4 zeroes the watchdog counter; each tick increments it. When the counter reaches WDOG_TICKS, go to EXPIRED.
  - EXPIRED: `wdog_expired`=1; all targets forced to 0; enable requests cleared; duties ramp down at SLEW_STEP. Writes to addr 0–4 are acked and discarded. A write of 10'h15A to addr 5 goes to RUN with counter 0 and targets still 0. Any other data to addr 5 is ignored.
- `ramp_busy` = OR over channels of (cur≠tgt or out≠cur).

## Timing
- Reset values: every duty output 0, both enables 0, `wdog_expired` 0, `wr_ack` 0, `ramp_busy` 0, state IDLE.
- Write latency:
  - `wr_ack` and the `tgt` update occur one cycle after `wr_en`.
  - The first slew step happens on the next `pulse_200us` after `tgt` updates.
  - The port changes on the next `start_pwm_period` after that step.
- Simultaneous events:
  - `wr_en` in the same cycle as `pulse_200us`: the step uses the old tgt.
  - `pulse_200us` in the same cycle as `start_pwm_period`: out loads the pre-step cur.
  - `wr_en` (addr 0–4) in the same cycle as the expiring tick: the write wins, the counter resets and there is no expiry.
- Reset mid-ramp or mid-EXPIRED: all registers clear asynchronously; outputs read 0 immediately.

## Structure
- `cmn_pwm_pkg` holds:
  - address constants ADDR_P01..ADDR_CLR;
  - WDOG_KEY = 10'h15A;
  - state enum {IDLE, RUN, EXPIRED}.
- Sub-module `cmn_slew_lim`: one channel's `cur` register and step logic, instantiated 4×.
- Top level contains the host decode, `tgt`/`out` registers, enables, watchdog counter and FSM.

## Test plan
- Reset, then write addr0=10'h100 and addr4=2'b11 → after 32 ticks cur=0x100; the port shows 0x100 at the next period strobe; `mot_en_in`/`brk_en_in` rise at the first strobe after the addr4 write.
- Ramp down from tgt 0x100 to 0x005 → 31 steps of −8 then one of −3; final value 0x005 with no undershoot; `ramp_busy` falls after the port loads.
- Limits: 0x3FC→0x3FF settles in one tick with no overflow; 0x003→0x000 settles in one tick; `SLEW_STEP` exact difference settles in one tick.
- Watchdog:
  - 50 ticks without a write → `wdog_expired`=1 and both enables 0 on the next edge; duties ramp to 0.
  - addr0 write is discarded.
  - addr5=10'h155 is ignored.
  - addr5=10'h15A returns to RUN.
- Coincidences:
  - `wr_en` on the 50th tick → no expiry.
  - `pulse_200us` with `start_pwm_period` in the same cycle → port gets the pre-step value.
- Reset asserted mid-ramp between clock edges → all outputs 0 before the next edge; the first write afterwards leaves IDLE.
